// File: rtl/display_scheduler_pkg.sv
// display_scheduler_pkg: shared digit codes, FSM state encoding and counter width.
// Imported by the scheduler top and its tick counter.
// Contents: CODE_BLANK/digit code limits, state_e enum, CTR_W, tick-parameter helper.
package display_scheduler_pkg;

  // Seven-segment code space: digits 0..9 map to codes 0..9, 21 blanks the digit.
  localparam int unsigned CODE_BLANK     = 21;
  localparam int unsigned CODE_DIGIT_MAX = 9;

  // All timebase counters are 16 bits wide.
  localparam int unsigned CTR_W = 16;

  typedef enum logic [1:0] {
    SHOW_ENTRY = 2'd0,
    SHOW_MSG   = 2'd1,
    SHOW_ALERT = 2'd2
  } state_e;

  // A zero tick count would make the terminal value underflow; treat it as 1.
  function automatic int unsigned ticks_or_one(input int unsigned t);
    return (t == 0) ? 1 : t;
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// display_scheduler_if: requester and display-side signals of the display scheduler.
// master = requesters/timebase (drive requests, entry digits, tick, cancel);
// slave  = the scheduler (drives acks, digit1..4, busy, done).
interface display_scheduler_if #(
  parameter int unsigned CODE_W = 5
);

  logic              tick;
  logic [CODE_W-1:0] entry_d1, entry_d2, entry_d3, entry_d4;
  logic [2:0]        entry_cursor;
  logic              msg_req;
  logic [CODE_W-1:0] msg_d1, msg_d2, msg_d3, msg_d4;
  logic              msg_ack;
  logic              alert_req;
  logic [CODE_W-1:0] alert_d1, alert_d2, alert_d3, alert_d4;
  logic              alert_ack;
  logic              cancel;
  logic [CODE_W-1:0] digit1, digit2, digit3, digit4;
  logic              busy;
  logic              done;

  modport master (
    output tick, entry_d1, entry_d2, entry_d3, entry_d4, entry_cursor,
           msg_req, msg_d1, msg_d2, msg_d3, msg_d4,
           alert_req, alert_d1, alert_d2, alert_d3, alert_d4, cancel,
    input  msg_ack, alert_ack, digit1, digit2, digit3, digit4, busy, done
  );

  modport slave (
    input  tick, entry_d1, entry_d2, entry_d3, entry_d4, entry_cursor,
           msg_req, msg_d1, msg_d2, msg_d3, msg_d4,
           alert_req, alert_d1, alert_d2, alert_d3, alert_d4, cancel,
    output msg_ack, alert_ack, digit1, digit2, digit3, digit4, busy, done
  );

endinterface

// File: rtl/display_scheduler_tick_counter.sv
// tick_counter: 16-bit tick-enabled counter, wraps after TERM ticks, pulses tc_o on the wrapping tick.
// Latency: tc_o is combinational from the count register and en_i; count updates on the next edge.
// Ports: clk, rst_n, en_i (tick), clr_i (sync clear, wins over en_i), tc_o (terminal-count pulse).
module tick_counter
  import display_scheduler_pkg::*;
#(
  parameter int unsigned TERM = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam logic [CTR_W-1:0] LAST = CTR_W'(TERM - 1);

  logic [CTR_W-1:0] cnt_q, cnt_d;

  // tc_o deliberately ignores clr_i: the owner derives its clear from tc_o.
  assign tc_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: arbitrates the 4-digit display between live entry, messages and alerts.
// Latency: request -> ack pulse and new digits on the next edge; expiry -> done on the next edge.
// Backpressure: level req held until ack; alerts preempt messages, a message waits out an alert.
// Ports: clk, rst_n (async, active low), bus (display_scheduler_if.slave).
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned HOLD_TICKS  = 2000,
  parameter int unsigned BLINK_TICKS = 250,
  parameter int unsigned CODE_W      = 5
) (
  input logic                clk,
  input logic                rst_n,
  display_scheduler_if.slave bus
);

  localparam logic [CODE_W-1:0] BLANK   = CODE_W'(CODE_BLANK);
  localparam int unsigned       HOLD_T  = ticks_or_one(HOLD_TICKS);
  localparam int unsigned       BLINK_T = ticks_or_one(BLINK_TICKS);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] msg_q [4];
  logic [CODE_W-1:0] msg_d [4];
  logic [CODE_W-1:0] alt_q [4];
  logic [CODE_W-1:0] alt_d [4];
  logic [CODE_W-1:0] dig_q [4];
  logic [CODE_W-1:0] dig_d [4];
  logic [CODE_W-1:0] entry_w [4];
  logic [CODE_W-1:0] msg_w [4];
  logic [CODE_W-1:0] alt_w [4];

  logic msg_ack_q, msg_ack_d;
  logic alert_ack_q, alert_ack_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pending_q, pending_d;
  logic phase_q, phase_d;

  logic take_msg, take_alert;
  logic hold_clr, hold_tc;
  logic blink_clr, blink_tc;

  assign entry_w[0] = bus.entry_d1;
  assign entry_w[1] = bus.entry_d2;
  assign entry_w[2] = bus.entry_d3;
  assign entry_w[3] = bus.entry_d4;
  assign msg_w[0]   = bus.msg_d1;
  assign msg_w[1]   = bus.msg_d2;
  assign msg_w[2]   = bus.msg_d3;
  assign msg_w[3]   = bus.msg_d4;
  assign alt_w[0]   = bus.alert_d1;
  assign alt_w[1]   = bus.alert_d2;
  assign alt_w[2]   = bus.alert_d3;
  assign alt_w[3]   = bus.alert_d4;

  // Hold timer only runs while a message/alert is on screen; any acceptance restarts it.
  assign hold_clr  = take_msg || take_alert || bus.cancel || (state_q == SHOW_ENTRY);
  // Blink timer only runs while entry digits are shown.
  assign blink_clr = (state_q != SHOW_ENTRY);

  tick_counter #(.TERM(HOLD_T)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (bus.tick),
    .clr_i (hold_clr),
    .tc_o  (hold_tc)
  );

  tick_counter #(.TERM(BLINK_T)) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (bus.tick),
    .clr_i (blink_clr),
    .tc_o  (blink_tc)
  );

  // Next state, acceptance and done generation.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    done_d      = 1'b0;
    take_msg    = 1'b0;
    take_alert  = 1'b0;

    if (bus.cancel) begin
      state_d   = SHOW_ENTRY;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        SHOW_ENTRY: begin
          if (bus.alert_req) begin
            take_alert = 1'b1;
          end else if (bus.msg_req) begin
            take_msg = 1'b1;
          end
        end
        SHOW_MSG: begin
          // Natural expiry takes precedence so done still pulses if an alert lands on that tick.
          if (hold_tc) begin
            done_d = 1'b1;
            if (bus.alert_req) begin
              take_alert = 1'b1;
            end else if (bus.msg_req) begin
              take_msg = 1'b1;
            end else begin
              state_d = SHOW_ENTRY;
            end
          end else if (bus.alert_req) begin
            take_alert = 1'b1;
          end
        end
        SHOW_ALERT: begin
          if (hold_tc) begin
            done_d    = 1'b1;
            pending_d = 1'b0;
            if (bus.alert_req) begin
              take_alert = 1'b1;
            end else if (bus.msg_req) begin
              take_msg = 1'b1;
            end else begin
              state_d = SHOW_ENTRY;
            end
          end else if (bus.msg_req) begin
            // Message waits; the requester keeps msg_req high until the alert expires.
            pending_d = 1'b1;
          end
        end
        default: state_d = SHOW_ENTRY;
      endcase
    end

    if (take_alert) state_d = SHOW_ALERT;
    if (take_msg)   state_d = SHOW_MSG;
  end

  // Payload latches, blink phase and registered display outputs.
  always_comb begin
    msg_ack_d   = take_msg;
    alert_ack_d = take_alert;
    busy_d      = (state_d != SHOW_ENTRY);
    phase_d     = (state_q == SHOW_ENTRY) ? (phase_q ^ blink_tc) : 1'b0;

    for (int i = 0; i < 4; i++) begin
      msg_d[i] = take_msg   ? msg_w[i] : msg_q[i];
      alt_d[i] = take_alert ? alt_w[i] : alt_q[i];
      dig_d[i] = entry_w[i];
    end

    // Digits follow the next state/phase so the display changes on the same edge.
    case (state_d)
      SHOW_MSG: begin
        for (int i = 0; i < 4; i++) dig_d[i] = msg_d[i];
      end
      SHOW_ALERT: begin
        for (int i = 0; i < 4; i++) dig_d[i] = alt_d[i];
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          if (phase_d && (bus.entry_cursor == 3'(i + 1))) dig_d[i] = BLANK;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SHOW_ENTRY;
      msg_q       <= '{default: BLANK};
      alt_q       <= '{default: BLANK};
      dig_q       <= '{default: BLANK};
      msg_ack_q   <= 1'b0;
      alert_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pending_q   <= 1'b0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      alt_q       <= alt_d;
      dig_q       <= dig_d;
      msg_ack_q   <= msg_ack_d;
      alert_ack_q <= alert_ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pending_q   <= pending_d;
      phase_q     <= phase_d;
    end
  end

  assign bus.digit1    = dig_q[0];
  assign bus.digit2    = dig_q[1];
  assign bus.digit3    = dig_q[2];
  assign bus.digit4    = dig_q[3];
  assign bus.msg_ack   = msg_ack_q;
  assign bus.alert_ack = alert_ack_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed bench for display_scheduler (HOLD_TICKS=3, BLINK_TICKS=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Tick pulses for one clock out of every four.
module tb_display_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [19:0] got;
  logic [19:0] exp;

  display_scheduler_if #(.CODE_W(5)) bus ();

  display_scheduler #(
    .HOLD_TICKS  (3),
    .BLINK_TICKS (2),
    .CODE_W      (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] digs();
    return {bus.digit1, bus.digit2, bus.digit3, bus.digit4};
  endfunction

  function automatic logic [19:0] exp4(input logic [4:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input logic [4:0] a, b, c, d);
    bus.msg_d1 = a; bus.msg_d2 = b; bus.msg_d3 = c; bus.msg_d4 = d;
  endtask

  task automatic set_alert(input logic [4:0] a, b, c, d);
    bus.alert_d1 = a; bus.alert_d2 = b; bus.alert_d3 = c; bus.alert_d4 = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    got = digs(); exp = exp4(21, 21, 21, 21);
    checks++; if (got !== exp) begin errors++; $display("FAIL reset_digits got %h expected %h", got, exp); end
    checks++; if ({bus.busy, bus.done, bus.msg_ack, bus.alert_ack} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b expected 0000", {bus.busy, bus.done, bus.msg_ack, bus.alert_ack});
    end
    rst_n = 1'b1;
    cyc();
    got = digs(); exp = exp4(1, 2, 3, 4);
    checks++; if (got !== exp) begin errors++; $display("FAIL release_digits got %h expected %h", got, exp); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_blink();
    logic [4:0] exp_d2 [4];
    exp_d2 = '{5'd2, 5'd21, 5'd21, 5'd2};
    bus.entry_cursor = 3'd2;
    cyc();
    got = digs(); exp = exp4(1, 2, 3, 4);
    checks++; if (got !== exp) begin errors++; $display("FAIL blink_start got %h expected %h", got, exp); end
    for (int k = 0; k < 4; k++) begin
      bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
      got = digs(); exp = exp4(1, exp_d2[k], 3, 4);
      checks++; if (got !== exp) begin errors++; $display("FAIL blink_tick%0d got %h expected %h", k + 1, got, exp); end
      cyc(); cyc(); cyc();
    end
    bus.entry_cursor = 3'd0;
    cyc();
  endtask

  task automatic test_msg();
    set_msg(10, 11, 12, 13);
    bus.msg_req = 1'b1;
    cyc();
    bus.msg_req = 1'b0;
    got = digs(); exp = exp4(10, 11, 12, 13);
    checks++; if (got !== exp) begin errors++; $display("FAIL msg_digits got %h expected %h", got, exp); end
    checks++; if ({bus.msg_ack, bus.alert_ack, bus.busy} !== 3'b101) begin
      errors++; $display("FAIL msg_ack_busy got %b expected 101", {bus.msg_ack, bus.alert_ack, bus.busy});
    end
    cyc();
    checks++; if (bus.msg_ack !== 1'b0) begin errors++; $display("FAIL msg_ack_pulse got %b expected 0", bus.msg_ack); end
    for (int k = 1; k <= 3; k++) begin
      bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
      checks++; if (bus.done !== 1'(k == 3)) begin errors++; $display("FAIL msg_done_t%0d got %b expected %b", k, bus.done, k == 3); end
      checks++; if (bus.busy !== 1'(k < 3)) begin errors++; $display("FAIL msg_busy_t%0d got %b expected %b", k, bus.busy, k < 3); end
      got = digs(); exp = (k == 3) ? exp4(1, 2, 3, 4) : exp4(10, 11, 12, 13);
      checks++; if (got !== exp) begin errors++; $display("FAIL msg_digits_t%0d got %h expected %h", k, got, exp); end
      cyc();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL msg_done_pulse_t%0d got %b expected 0", k, bus.done); end
      cyc(); cyc();
    end
  endtask

  task automatic test_alert_vs_msg();
    set_msg(10, 11, 12, 13);
    set_alert(14, 15, 16, 17);
    bus.msg_req = 1'b1;
    bus.alert_req = 1'b1;
    cyc();
    bus.alert_req = 1'b0;
    checks++; if ({bus.alert_ack, bus.msg_ack} !== 2'b10) begin
      errors++; $display("FAIL both_acks got %b expected 10", {bus.alert_ack, bus.msg_ack});
    end
    got = digs(); exp = exp4(14, 15, 16, 17);
    checks++; if (got !== exp) begin errors++; $display("FAIL both_alert_digits got %h expected %h", got, exp); end
    for (int k = 1; k <= 3; k++) begin
      bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
      checks++; if ({bus.done, bus.msg_ack} !== {1'(k == 3), 1'(k == 3)}) begin
        errors++; $display("FAIL pend_done_ack_t%0d got %b expected %b", k, {bus.done, bus.msg_ack}, {1'(k == 3), 1'(k == 3)});
      end
      got = digs(); exp = (k == 3) ? exp4(10, 11, 12, 13) : exp4(14, 15, 16, 17);
      checks++; if (got !== exp) begin errors++; $display("FAIL pend_digits_t%0d got %h expected %h", k, got, exp); end
      if (k == 3) bus.msg_req = 1'b0;
      cyc(); cyc(); cyc();
    end
    for (int k = 1; k <= 3; k++) begin
      bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
      checks++; if (bus.done !== 1'(k == 3)) begin errors++; $display("FAIL pmsg_done_t%0d got %b expected %b", k, bus.done, k == 3); end
      checks++; if (bus.busy !== 1'(k < 3)) begin errors++; $display("FAIL pmsg_busy_t%0d got %b expected %b", k, bus.busy, k < 3); end
      cyc(); cyc(); cyc();
    end
  endtask

  task automatic test_preempt();
    set_msg(10, 11, 12, 13);
    set_alert(18, 19, 20, 0);
    bus.msg_req = 1'b1;
    cyc();
    bus.msg_req = 1'b0;
    checks++; if (bus.msg_ack !== 1'b1) begin errors++; $display("FAIL pre_msg_ack got %b expected 1", bus.msg_ack); end
    bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
    cyc();
    bus.alert_req = 1'b1;
    cyc();
    bus.alert_req = 1'b0;
    checks++; if ({bus.alert_ack, bus.done, bus.busy} !== 3'b101) begin
      errors++; $display("FAIL pre_alert_ack got %b expected 101", {bus.alert_ack, bus.done, bus.busy});
    end
    got = digs(); exp = exp4(18, 19, 20, 0);
    checks++; if (got !== exp) begin errors++; $display("FAIL pre_alert_digits got %h expected %h", got, exp); end
    cyc(); cyc();
    for (int k = 1; k <= 3; k++) begin
      bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
      checks++; if (bus.done !== 1'(k == 3)) begin errors++; $display("FAIL pre_done_t%0d got %b expected %b", k, bus.done, k == 3); end
      got = digs(); exp = (k == 3) ? exp4(1, 2, 3, 4) : exp4(18, 19, 20, 0);
      checks++; if (got !== exp) begin errors++; $display("FAIL pre_digits_t%0d got %h expected %h", k, got, exp); end
      cyc(); cyc(); cyc();
    end
  endtask

  task automatic test_cancel();
    set_alert(14, 15, 16, 17);
    bus.alert_req = 1'b1;
    cyc();
    bus.alert_req = 1'b0;
    checks++; if (bus.alert_ack !== 1'b1) begin errors++; $display("FAIL can_alert_ack got %b expected 1", bus.alert_ack); end
    bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
    cyc();
    bus.cancel = 1'b1;
    bus.alert_req = 1'b1;
    cyc();
    bus.cancel = 1'b0;
    bus.alert_req = 1'b0;
    got = digs(); exp = exp4(1, 2, 3, 4);
    checks++; if (got !== exp) begin errors++; $display("FAIL can_digits got %h expected %h", got, exp); end
    checks++; if ({bus.busy, bus.done, bus.alert_ack, bus.msg_ack} !== 4'b0000) begin
      errors++; $display("FAIL can_flags got %b expected 0000", {bus.busy, bus.done, bus.alert_ack, bus.msg_ack});
    end
    for (int k = 1; k <= 4; k++) begin
      bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
      checks++; if ({bus.busy, bus.done, bus.alert_ack} !== 3'b000) begin
        errors++; $display("FAIL can_after_t%0d got %b expected 000", k, {bus.busy, bus.done, bus.alert_ack});
      end
      cyc(); cyc(); cyc();
    end
  endtask

  task automatic test_async_reset();
    set_msg(10, 11, 12, 13);
    bus.msg_req = 1'b1;
    cyc();
    bus.msg_req = 1'b0;
    bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    got = digs(); exp = exp4(21, 21, 21, 21);
    checks++; if (got !== exp) begin errors++; $display("FAIL arst_digits got %h expected %h", got, exp); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b expected 0", bus.busy); end
    cyc();
    rst_n = 1'b1;
    cyc();
    got = digs(); exp = exp4(1, 2, 3, 4);
    checks++; if (got !== exp) begin errors++; $display("FAIL arst_release got %h expected %h", got, exp); end
    for (int k = 1; k <= 4; k++) begin
      bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
      checks++; if ({bus.done, bus.msg_ack, bus.busy} !== 3'b000) begin
        errors++; $display("FAIL arst_after_t%0d got %b expected 000", k, {bus.done, bus.msg_ack, bus.busy});
      end
      cyc(); cyc(); cyc();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.tick = 1'b0;
    bus.entry_d1 = 5'd1; bus.entry_d2 = 5'd2; bus.entry_d3 = 5'd3; bus.entry_d4 = 5'd4;
    bus.entry_cursor = 3'd0;
    bus.msg_req = 1'b0;
    bus.alert_req = 1'b0;
    bus.cancel = 1'b0;
    set_msg(0, 0, 0, 0);
    set_alert(0, 0, 0, 0);

    test_reset();
    test_blink();
    test_msg();
    test_alert_vs_msg();
    test_preempt();
    test_cancel();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Shares the four-digit seven-segment display between three requesters:
  - the lock FSM's live digit entry (background),
  - transient status messages (e.g. OPEN, LOCK),
  - high-priority alerts (e.g. wrong password).
- Latches message/alert payloads, holds them for a programmable time, then reverts to entry.
- Applies cursor blinking to entry digits.
- Drives the digit1..digit4 inputs of the display multiplexer; all outputs are registered.

Parameters:
- HOLD_TICKS, 2000, number of tick pulses a message or alert stays on screen (1..65535).
- BLINK_TICKS, 250, tick pulses per blink half-period for the cursor digit (1..65535).
- CODE_W, 5, width of a digit code.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle timebase enable (1 kHz nominal), from the clock divider
- entry_d1..entry_d4  in  CODE_W each  live entry digits from lock FSM
- entry_cursor  in  3  active entry position 1..4; 0 = no cursor
- msg_req  in  1  message request, level, held until msg_ack
- msg_d1..msg_d4  in  CODE_W each  message payload, valid while msg_req=1
- msg_ack  out  1  one-cycle pulse: payload latched
- alert_req  in  1  alert request, level, held until alert_ack
- alert_d1..alert_d4  in  CODE_W each  alert payload
- alert_ack  out  1  one-cycle pulse: payload latched
- cancel  in  1  abort any message/alert, return to entry
- digit1..digit4  out  CODE_W each  codes to display multiplexer
- busy  out  1  1 while a message or alert is shown
- done  out  1  one-cycle pulse when a hold expires naturally

Behaviour:
- Reset (rst=0, async):
  - state=SHOW_ENTRY; digit1..4=CODE_BLANK (21).
  - msg_ack=alert_ack=busy=done=0.
  - Hold counter=0, blink counter=0, blink phase=0, msg_pending=0.
  - Reset mid-display discards the payload; no ack or done is issued afterwards.
- States:
  - SHOW_ENTRY: digitN = entry_dN, except digit[entry_cursor] = CODE_BLANK when blink phase=1.
    - Blink counter counts ticks only in this state.
    - Phase toggles when the counter reaches BLINK_TICKS-1; counter then wraps to 0.
    - Leaving SHOW_ENTRY resets the counter and phase to 0.
  - SHOW_MSG: digits = latched msg payload. busy=1.
  - SHOW_ALERT: digits = latched alert payload. busy=1.
- Acceptance:
  - A request sampled at rising edge N produces the ack pulse and the new digits at edge N+1 (one-cycle latency).
  - The hold counter clears on acceptance and increments on each tick.
  - Expiry occurs at the tick that makes the count HOLD_TICKS; done pulses on the following edge.
- Transitions:
  - SHOW_ENTRY + alert_req -> SHOW_ALERT, alert_ack.
  - SHOW_ENTRY + msg_req (no alert_req) -> SHOW_MSG, msg_ack.
  - SHOW_MSG + alert_req -> preempt to SHOW_ALERT, alert_ack. The remaining message is dropped without done.
  - SHOW_ALERT + msg_req -> msg_pending=1. No ack; the requester keeps msg_req high.
  - SHOW_MSG + new msg_req -> ignored until expiry.
  - Expiry in SHOW_ALERT: if alert_req=1, re-accept the alert. Else if msg_req=1, go to SHOW_MSG with msg_ack. Else go to SHOW_ENTRY. done pulses in all three cases.
  - Expiry in SHOW_MSG: same priority order.
  - cancel=1 in any state -> SHOW_ENTRY next edge, busy=0, no done. cancel has priority over simultaneous requests in that cycle.
- Simultaneous events:
  - alert_req and msg_req both high in SHOW_ENTRY -> alert wins.
  - The message is acked only after the alert expires, provided msg_req is still high.
- Width: counters are 16 bits. The tick input is the only timebase; clk-only cycles never advance counters.
- Requesters must drop req within one cycle of ack, otherwise a second acceptance follows at the next expiry.

Decomposition:
- Shared package holds:
  - digit-code constants: CODE_BLANK=21; digits 0..9 = codes 0..9.
  - state encoding: SHOW_ENTRY=0, SHOW_MSG=1, SHOW_ALERT=2.
- One sub-module: tick_counter. A 16-bit, tick-enabled, clearable counter with a terminal-count pulse, used twice (hold and blink).

Test Plan (HOLD_TICKS=3, BLINK_TICKS=2, tick every 4 clk):
- Reset with entry=1,2,3,4, cursor=0 -> digits blank during reset; 1,2,3,4 one edge after release; busy=0.
- Cursor=2 -> digit2 alternates 2/21 every 2 ticks; digits 1, 3, 4 steady.
- msg_req with payload 10,11,12,13 -> msg_ack at N+1, digits 10..13, busy=1. After the 3rd tick, done pulses once, digits return to entry, busy=0.
- alert_req and msg_req raised on the same edge -> alert_ack only. After 3 ticks, done plus msg_ack; message shown for 3 more ticks.
- During a message, raise alert_req at tick 1 -> preempt; alert payload shown; no done for the message.
- During an alert, assert cancel and alert_req together -> entry digits next edge, busy=0, no done, no ack. Async reset asserted mid-hold -> outputs blank immediately.
